// File: rtl/regbank_exec_unit.sv
// Execute/writeback stage behind a 32x32 register bank: selects operands, runs an ALU op
// or a 32-step shift-add multiply, then writes the result back with a one-cycle strobe.
module regbank_exec_unit #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic [AW-1:0] rd,
    output logic [AW-1:0] sr1,
    output logic [AW-1:0] sr2,
    input  logic [DW-1:0] rdData1,
    input  logic [DW-1:0] rdData2,
    output logic [AW-1:0] dr,
    output logic [DW-1:0] wrData,
    output logic          write,
    output logic          busy
);

    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

    state_t        state, state_nxt;
    logic [2:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] mcand;
    logic [DW-1:0] mplier;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_nxt;
    logic [CW-1:0] cnt;
    logic          accept;

    function automatic logic [DW-1:0] alu(input logic [2:0] code,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (code)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = a << b[4:0];
            3'b110:  r = a >> b[4:0];
            default: r = '0;
        endcase
        return r;
    endfunction

    assign in_ready = (state == IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    // Strobe is decoded from state so an async reset kills it immediately.
    assign write    = (state == WB) && (rd_q != '0);
    assign acc_nxt  = mplier[0] ? acc + mcand : acc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = EXEC;
            EXEC: state_nxt = (op_q == OP_MUL) ? MUL : WB;
            MUL:  if (cnt == LAST_STEP) state_nxt = WB;
            WB:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            rd_q   <= '0;
            sr1    <= '0;
            sr2    <= '0;
            dr     <= '0;
            wrData <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= op;
                        rd_q <= rd;
                        sr1  <= rs1;
                        sr2  <= rs2;
                    end
                end
                EXEC: begin
                    if (op_q == OP_MUL) begin
                        mcand  <= rdData1;
                        mplier <= rdData2;
                        acc    <= '0;
                        cnt    <= '0;
                    end else begin
                        dr     <= rd_q;
                        wrData <= alu(op_q, rdData1, rdData2);
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // The last step's sum goes straight to the write port.
                    if (cnt == LAST_STEP) begin
                        dr     <= rd_q;
                        wrData <= acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_exec_unit.sv
// Scoreboard bench for regbank_exec_unit with a behavioural 32x32 register bank attached.
module tb_regbank_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [4:0]  sr1, sr2, dr;
    logic [31:0] rdData1, rdData2, wrData;
    logic        write, busy;

    logic [31:0] mem [32];
    logic        bd_en = 1'b0;
    logic [4:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    typedef struct {
        logic [4:0]  dr;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int busy_cnt = 0;
    int accept_cnt = 0;

    regbank_exec_unit #(.DW(32), .AW(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .sr1(sr1), .sr2(sr2),
        .rdData1(rdData1), .rdData2(rdData2), .dr(dr), .wrData(wrData),
        .write(write), .busy(busy)
    );

    always #5 clk = ~clk;

    assign rdData1 = mem[sr1];
    assign rdData2 = mem[sr2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (write) mem[dr] <= wrData;
        else if (bd_en) mem[bd_addr] <= bd_data;
        if (in_valid && in_ready) accept_cnt <= accept_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (busy) busy_cnt <= busy_cnt + 1;
        if (write) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got dr=%0d data=%0h expected no write", dr, wrData);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("wb_dr", 32'(dr), 32'(e.dr));
                chk("wb_data", wrData, e.data);
                chk("wb_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic [31:0] exp, input int lat,
                         input bit push);
        int w;
        w = 0;
        @(negedge clk);
        in_valid = 1'b1; op = o; rs1 = a; rs2 = b; rd = d;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (push) sb_q.push_back('{d, exp, cyc + lat});
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while ((busy || sb_q.size() != 0) && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (busy || sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=%0d pending=%0d expected 0", busy, sb_q.size());
        end
    endtask

    task automatic bd_write(input logic [4:0] a, input logic [31:0] v);
        @(negedge clk);
        bd_en = 1'b1; bd_addr = a; bd_data = v;
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) bd_write(5'(k), 32'(10 * k));

        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_write", 32'(write), 0);
        chk("rst_sr1", 32'(sr1), 0);
        chk("rst_sr2", 32'(sr2), 0);
        chk("rst_dr", 32'(dr), 0);
        chk("rst_wrdata", wrData, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 1);

        busy_cnt = 0;
        issue(3'b000, 5'd3, 5'd4, 5'd5, 32'd70, 1, 1'b1);
        wait_idle();
        chk("add_busy_cycles", 32'(busy_cnt), 2);
        chk("add_readback", mem[5], 32'd70);
        chk("add_busy_after", 32'(busy), 0);

        issue(3'b001, 5'd3, 5'd4, 5'd6, 32'hFFFF_FFF6, 1, 1'b1);
        wait_idle();

        busy_cnt = 0;
        issue(3'b111, 5'd7, 5'd9, 5'd8, 32'd6300, 33, 1'b1);
        wait_idle();
        chk("mul_busy_cycles", 32'(busy_cnt), 34);

        issue(3'b100, 5'd1, 5'd2, 5'd7, 32'd30, 1, 1'b1);
        issue(3'b110, 5'd31, 5'd1, 5'd12, 32'd0, 1, 1'b1);
        issue(3'b010, 5'd7, 5'd5, 5'd14, 32'd6, 1, 1'b1);
        issue(3'b011, 5'd7, 5'd5, 5'd15, 32'd94, 1, 1'b1);
        issue(3'b101, 5'd1, 5'd1, 5'd16, 32'd10240, 1, 1'b1);
        wait_idle();

        bd_write(5'd9, 32'hFFFF_FFFF);
        issue(3'b111, 5'd9, 5'd2, 5'd13, 32'hFFFF_FFEC, 33, 1'b1);
        wait_idle();

        // rd==0: full sequence, no strobe
        issue(3'b000, 5'd1, 5'd2, 5'd0, 32'd0, 1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rd0_ready_wb", 32'(in_ready), 0);
        @(negedge clk);
        chk("rd0_ready_after", 32'(in_ready), 1);
        chk("rd0_reg0", mem[0], 32'd0);

        // Back-to-back dependent instructions
        issue(3'b000, 5'd1, 5'd1, 5'd10, 32'd20, 1, 1'b1);
        issue(3'b000, 5'd10, 5'd1, 5'd11, 32'd30, 1, 1'b1);
        wait_idle();
        chk("b2b_readback", mem[11], 32'd30);

        // in_valid held high through a multiply
        @(negedge clk);
        accept_cnt = 0;
        in_valid = 1'b1; op = 3'b111; rs1 = 5'd2; rs2 = 5'd3; rd = 5'd17;
        @(posedge clk);
        #1;
        sb_q.push_back('{5'd17, 32'd600, cyc + 33});
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            op = 3'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31));
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();
        chk("held_valid_accepts", 32'(accept_cnt), 1);

        // Reset in the middle of a multiply
        issue(3'b111, 5'd2, 5'd3, 5'd18, 32'd0, 33, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_write", 32'(write), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        chk("abort_outputs", {write, busy, in_ready, sr1, sr2, dr, wrData}, 0);
        repeat (3) @(negedge clk);
        chk("abort_busy_hold", 32'(busy), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 1);
        issue(3'b000, 5'd3, 5'd4, 5'd19, 32'd70, 1, 1'b1);
        wait_idle();
        chk("post_rst_readback", mem[19], 32'd70);
        chk("mul_abort_no_write", mem[18], 32'd180);

        repeat (5) @(negedge clk);
        chk("pending_expect", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regbank_exec_unit.md
Name: regbank_exec_unit

Overview:
- Execute/writeback stage directly downstream of the 32x32 register bank.
- Accepts one instruction at a time over a valid/ready handshake and drives the bank's read selects (sr1/sr2).
- Captures the combinational read data, performs an ALU operation or a 32-cycle iterative multiply, then issues a single-cycle write (dr/wrData/write) back into the bank.

Parameters:
- DW, 32, datapath width; operand, result and wrData width.
- AW, 5, register address width; 2^AW registers.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  unit can accept an instruction this cycle.
- op  input  3  operation code, sampled at accept.
- rs1  input  AW  source register 1 index.
- rs2  input  AW  source register 2 index.
- rd  input  AW  destination register index.
- sr1  output  AW  register bank read select 1 (registered).
- sr2  output  AW  register bank read select 2 (registered).
- rdData1  input  DW  register bank read data 1 (combinational from sr1).
- rdData2  input  DW  register bank read data 2 (combinational from sr2).
- dr  output  AW  register bank write address.
- wrData  output  DW  register bank write data.
- write  output  1  register bank write enable, one cycle per instruction.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; sr1, sr2, dr, wrData, write, busy all 0; internal operand, accumulator and counter registers cleared.
  - in_ready=0 while reset is high.
- Accept: in_valid && in_ready at a rising edge (edge E0).
  - Latch op and rd.
  - sr1<=rs1, sr2<=rs2; both hold until the next accept.
- States:
  - IDLE: in_ready=1; on accept go to EXEC. in_valid with no accept has no effect.
  - EXEC (one cycle, E0..E1):
    - Sample rdData1/rdData2.
    - op!=111: compute result, go to WB at E1.
    - op==111: load mcand=rdData1, mplier=rdData2, acc=0, cnt=0; go to MUL at E1.
  - MUL (exactly 32 cycles):
    - Each cycle: if mplier[0], acc<=acc+mcand; mcand<<=1; mplier>>=1; cnt<=cnt+1.
    - After the cycle in which cnt==31 (edge E33), result=acc; go to WB.
  - WB (one cycle):
    - dr=rd, wrData=result, write=(rd!=0); return to IDLE at the next edge.
    - Outside WB, write=0; dr and wrData hold their last values.
- Opcodes (all arithmetic modulo 2^DW, no flags):
  - 000 ADD; 001 SUB (rdData1-rdData2); 010 AND; 011 OR; 100 XOR.
  - 101 SLL and 110 SRL: logical shift of rdData1 by rdData2[4:0].
  - 111 MUL: low DW bits of the unsigned product.
- Latency:
  - ALU ops: write high in the cycle between E1 and E2.
  - MUL: write high in the cycle between E33 and E34.
  - Next accept possible at E2 (ALU) or E34 (MUL).
- Hazards: the bank write commits at the WB-ending edge, before the next EXEC samples. Back-to-back dependent instructions therefore read the updated value; no forwarding is needed.
- rd==0: the full sequence runs, but write stays 0 in WB.
- in_valid during busy: in_ready=0, ignored; instruction fields may change freely.
- Reset mid-EXEC, mid-MUL or mid-WB: immediate abort to IDLE, write drops to 0 asynchronously, and no partial write ever occurs.
- Shift amount ≥ DW is impossible by construction (5-bit field).

Test Plan:
- Preload the bank with reg[k]=10*k. Accept ADD rs1=3, rs2=4, rd=5 -> write=1 for exactly one cycle, 2 cycles after accept, dr=5, wrData=70; reg[5] reads back 70; busy low afterwards.
- SUB rs1=3, rs2=4, rd=6 -> wrData=32'hFFFFFFF6. XOR rs1=1, rs2=2, rd=7 -> wrData=10^20=30. SRL rs1=31, rs2=1 -> wrData=310>>10=0.
- MUL rs1=7, rs2=9, rd=8 -> busy for 34 cycles, single write at cycle 34, wrData=6300. MUL with reg[9]=32'hFFFFFFFF times reg[2]=20 -> wrData=32'hFFFFFFEC.
- ADD rs1=1, rs2=2, rd=0 -> no write pulse; reg[0] still reads 0; in_ready high 2 cycles after accept.
- Back-to-back: ADD rd=10 = reg[1]+reg[1] (20), then immediately ADD rd=11 = reg[10]+reg[1] -> second wrData=30. in_valid held high during MUL busy -> exactly one accept observed.
- Assert reset 10 cycles into a MUL -> write never pulses, busy=0 and all outputs 0 while reset is high; after deassert, in_ready=1 and a fresh ADD completes correctly.
